// File: rtl/block_sync_ctrl.sv
// Block-lock controller for the 64b/66b offset seeker tree: resets the seeker,
// qualifies its offset over repeated frames, holds lock and re-searches on loss.
module block_sync_ctrl #(
  parameter int unsigned SETTLE_CYC   = 4,
  parameter int unsigned CONFIRM_CNT  = 16,
  parameter int unsigned WINDOW       = 64,
  parameter int unsigned LOSS_THR     = 8,
  parameter int unsigned SEEK_TIMEOUT = 1024
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       seek_vld_i,
  input  logic       seek_synced_i,
  input  logic [6:0] seek_pos_i,
  output logic       seek_rst_o,
  output logic       locked_o,
  output logic [6:0] lock_pos_o,
  output logic [7:0] relock_cnt_o,
  output logic       timeout_o
);

  localparam int unsigned SettleW = $clog2(SETTLE_CYC + 1);
  localparam int unsigned ConfW   = $clog2(CONFIRM_CNT + 1);
  localparam int unsigned WinW    = $clog2(WINDOW + 1);
  localparam int unsigned BadW    = $clog2(LOSS_THR + 1);
  localparam int unsigned TmoW    = $clog2(SEEK_TIMEOUT + 1);

  localparam logic [SettleW-1:0] SettleLast = SettleW'(SETTLE_CYC - 1);
  localparam logic [ConfW-1:0]   ConfLast   = ConfW'(CONFIRM_CNT - 1);
  localparam logic [WinW-1:0]    WinLast    = WinW'(WINDOW - 1);
  localparam logic [BadW-1:0]    LossThr    = BadW'(LOSS_THR);
  localparam logic [TmoW-1:0]    TmoLast    = TmoW'(SEEK_TIMEOUT - 1);

  typedef enum logic [1:0] {StRstSeek, StSearch, StConfirm, StLocked} state_e;

  state_e             state_q, state_d;
  logic [SettleW-1:0] settle_q, settle_d;
  logic [ConfW-1:0]   conf_q, conf_d;
  logic [WinW-1:0]    win_q, win_d;
  logic [BadW-1:0]    bad_q, bad_d;
  logic [TmoW-1:0]    tmo_q, tmo_d;
  logic [6:0]         cand_q, cand_d;
  logic [6:0]         lock_pos_q, lock_pos_d;
  logic [7:0]         relock_q, relock_d;
  logic               seek_rst_q, seek_rst_d;
  logic               locked_q, locked_d;
  logic               timeout_q, timeout_d;

  logic               enter_rst, enter_lock, bad_frame;
  logic [BadW-1:0]    bad_nxt;

  always_comb begin
    state_d    = state_q;
    settle_d   = settle_q;
    conf_d     = conf_q;
    win_d      = win_q;
    bad_d      = bad_q;
    tmo_d      = tmo_q;
    cand_d     = cand_q;
    lock_pos_d = lock_pos_q;
    relock_d   = relock_q;
    seek_rst_d = seek_rst_q;
    locked_d   = locked_q;
    timeout_d  = 1'b0;
    enter_rst  = 1'b0;
    enter_lock = 1'b0;
    bad_frame  = !seek_synced_i || (seek_pos_i != lock_pos_q);
    bad_nxt    = bad_q + BadW'(bad_frame);

    unique case (state_q)
      StRstSeek: begin
        if (settle_q == SettleLast) begin
          state_d    = StSearch;
          seek_rst_d = 1'b0;
          settle_d   = '0;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      StSearch: begin
        if (seek_vld_i) begin
          if (seek_synced_i) begin
            cand_d  = seek_pos_i;
            conf_d  = ConfW'(1);
            state_d = StConfirm;
            if (CONFIRM_CNT <= 1) enter_lock = 1'b1;
          end else if (tmo_q == TmoLast) begin
            timeout_d = 1'b1;
            enter_rst = 1'b1;
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
        end
      end
      StConfirm: begin
        if (seek_vld_i) begin
          if (seek_synced_i && (seek_pos_i == cand_q)) begin
            if (conf_q == ConfLast) enter_lock = 1'b1;
            else                    conf_d = conf_q + 1'b1;
          end else begin
            // Disagreement falls back to search without resetting the seeker.
            state_d = StSearch;
            conf_d  = '0;
          end
        end
      end
      StLocked: begin
        if (seek_vld_i) begin
          // Threshold wins over a coincident window wrap.
          if (bad_nxt == LossThr) begin
            locked_d  = 1'b0;
            relock_d  = (relock_q == 8'hff) ? relock_q : relock_q + 1'b1;
            enter_rst = 1'b1;
          end else if (win_q == WinLast) begin
            win_d = '0;
            bad_d = '0;
          end else begin
            win_d = win_q + 1'b1;
            bad_d = bad_nxt;
          end
        end
      end
      default: enter_rst = 1'b1;
    endcase

    if (enter_rst) begin
      state_d    = StRstSeek;
      seek_rst_d = 1'b1;
      settle_d   = '0;
      conf_d     = '0;
      tmo_d      = '0;
      win_d      = '0;
      bad_d      = '0;
    end
    if (enter_lock) begin
      state_d    = StLocked;
      locked_d   = 1'b1;
      lock_pos_d = cand_d;
      conf_d     = '0;
      win_d      = '0;
      bad_d      = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StRstSeek;
      settle_q   <= '0;
      conf_q     <= '0;
      win_q      <= '0;
      bad_q      <= '0;
      tmo_q      <= '0;
      cand_q     <= '0;
      lock_pos_q <= '0;
      relock_q   <= '0;
      seek_rst_q <= 1'b1;
      locked_q   <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      settle_q   <= settle_d;
      conf_q     <= conf_d;
      win_q      <= win_d;
      bad_q      <= bad_d;
      tmo_q      <= tmo_d;
      cand_q     <= cand_d;
      lock_pos_q <= lock_pos_d;
      relock_q   <= relock_d;
      seek_rst_q <= seek_rst_d;
      locked_q   <= locked_d;
      timeout_q  <= timeout_d;
    end
  end

  assign seek_rst_o   = seek_rst_q;
  assign locked_o     = locked_q;
  assign lock_pos_o   = lock_pos_q;
  assign relock_cnt_o = relock_q;
  assign timeout_o    = timeout_q;

endmodule
